fog_sq_demod_accum: RTL

- Square-wave demodulator that sits directly upstream of the gated moving-average filter.
- Generates the modulation sign `mod_out` and counts ADC samples per modulation half-period.
- Integrates samples after a settling skip: adds them in the positive half, subtracts them in the negative half.
- At the end of each full period, emits one signed 32-bit error word with a single-cycle `trig` strobe. These are the filter's `din`/`trig` inputs.

---
 rtl/fog_pkg.sv | 22 ++
 rtl/fog_sq_demod_accum_if.sv | 29 ++
 rtl/fog_mod_phase_cnt.sv | 106 ++++++++++
 rtl/fog_sq_demod_accum.sv | 89 ++++++++
 4 files changed

// File: rtl/fog_pkg.sv
// Shared types and helpers for the square-wave demodulator slice.
// Contents: demod_state_t (IDLE/POS/NEG), DOUT_W (output error word width),
//           acc_width() (overflow-free accumulator width for a given ADC width
//           and half-period length).
package fog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } demod_state_t;

  localparam int unsigned DOUT_W = 32;

  // One period integrates at most 2*half_period samples, so adding that many
  // bits of growth plus a sign-guard bit keeps the sum exact.
  function automatic int unsigned acc_width(input int unsigned adc_w,
                                            input int unsigned half_period);
    return adc_w + $clog2(2 * half_period) + 1;
  endfunction

endpackage

// File: rtl/fog_sq_demod_accum_if.sv
// ADC-side and filter-side signal bundle of the square-wave demodulator.
// master: drives en/adc_valid/adc_data, observes mod_out/dout/trig/half_cnt.
// slave : the demodulator itself.
interface fog_sq_demod_accum_if
  import fog_pkg::*;
#(
  parameter int unsigned ADC_W = 16,
  parameter int unsigned CNT_W = 6
);

  logic                     en;
  logic                     adc_valid;
  logic signed [ADC_W-1:0]  adc_data;
  logic                     mod_out;
  logic signed [DOUT_W-1:0] dout;
  logic                     trig;
  logic [CNT_W-1:0]         half_cnt;

  modport master (
    output en, adc_valid, adc_data,
    input  mod_out, dout, trig, half_cnt
  );

  modport slave (
    input  en, adc_valid, adc_data,
    output mod_out, dout, trig, half_cnt
  );

endinterface

// File: rtl/fog_mod_phase_cnt.sv
// Modulation phase sequencer: IDLE/POS/NEG state machine, per-half sample
// counter and registered modulation sign.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   en              level enable; low forces IDLE on the next cycle
//   adc_valid       sample strobe; counter advances only on strobes
//   mod_out         registered modulation sign (1 = POS half)
//   half_cnt        sample index within the current half
//   is_integrating  current sample lies past the settling skip (en-qualified)
//   is_neg          current half is the negative half
//   period_done     this strobe is the final NEG sample of an enabled period
module fog_mod_phase_cnt
  import fog_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 64,
  parameter int unsigned SKIP        = 8,
  parameter int unsigned CNT_W       = $clog2(HALF_PERIOD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             adc_valid,
  output logic             mod_out,
  output logic [CNT_W-1:0] half_cnt,
  output logic             is_integrating,
  output logic             is_neg,
  output logic             period_done
);

  demod_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mod_q;
  logic             past_skip;
  logic             last_sample;

  // With no skip every sample integrates; avoids an always-true compare.
  if (SKIP == 0) begin : g_no_skip
    assign past_skip = 1'b1;
  end else begin : g_skip
    assign past_skip = (cnt_q >= CNT_W'(SKIP));
  end

  assign last_sample    = (cnt_q == CNT_W'(HALF_PERIOD - 1));
  assign is_neg         = (state_q == NEG);
  assign is_integrating = en && (state_q != IDLE) && past_skip;
  assign mod_out        = mod_q;
  assign half_cnt       = cnt_q;

  // State, counter and sign registers; mod_out follows the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mod_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mod_q   <= (state_d == POS);
    end
  end

  // Next-state and counter logic; en low aborts the period from any state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    period_done = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = POS;
      end
      POS: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (adc_valid) begin
          if (last_sample) begin
            state_d = NEG;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      NEG: begin
        if (!en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (adc_valid) begin
          if (last_sample) begin
            state_d     = POS;
            cnt_d       = '0;
            period_done = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/fog_sq_demod_accum.sv
// Square-wave demodulator feeding the gated moving-average filter: integrates
// +samples in the positive half and -samples in the negative half (after a
// settling skip) and emits one signed error word per full modulation period.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus (slave)    en, adc_valid, adc_data in; mod_out, dout, trig, half_cnt out
module fog_sq_demod_accum
  import fog_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 64,
  parameter int unsigned SKIP        = 8,
  parameter int unsigned ADC_W       = 16,
  parameter int unsigned CNT_W       = $clog2(HALF_PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  fog_sq_demod_accum_if.slave bus
);

  localparam int unsigned ACC_W = acc_width(ADC_W, HALF_PERIOD);

  // Elaboration-time parameter sanity.
  if (HALF_PERIOD < 2) begin : g_bad_half_period
    $error("fog_sq_demod_accum: HALF_PERIOD must be >= 2");
  end
  if (SKIP >= HALF_PERIOD) begin : g_bad_skip
    $error("fog_sq_demod_accum: SKIP must be < HALF_PERIOD");
  end
  if (ACC_W > DOUT_W) begin : g_bad_acc_w
    $error("fog_sq_demod_accum: accumulator wider than dout");
  end

  logic                     is_integrating;
  logic                     is_neg;
  logic                     period_done;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_upd;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [DOUT_W-1:0] dout_q;
  logic                     trig_q;

  fog_mod_phase_cnt #(
    .HALF_PERIOD (HALF_PERIOD),
    .SKIP        (SKIP),
    .CNT_W       (CNT_W)
  ) u_phase (
    .clk            (clk),
    .rst            (rst),
    .en             (bus.en),
    .adc_valid      (bus.adc_valid),
    .mod_out        (bus.mod_out),
    .half_cnt       (bus.half_cnt),
    .is_integrating (is_integrating),
    .is_neg         (is_neg),
    .period_done    (period_done)
  );

  assign sample_ext = ACC_W'(bus.adc_data);
  assign bus.dout   = dout_q;
  assign bus.trig   = trig_q;

  // Accumulator value including the current sample, when it counts.
  always_comb begin
    acc_upd = acc_q;
    if (bus.adc_valid && is_integrating) begin
      acc_upd = is_neg ? (acc_q - sample_ext) : (acc_q + sample_ext);
    end
  end

  // Accumulator and output registers; en low discards the partial period.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      dout_q <= '0;
      trig_q <= 1'b0;
    end else begin
      trig_q <= period_done;
      if (!bus.en) begin
        acc_q <= '0;
      end else if (period_done) begin
        dout_q <= DOUT_W'(acc_upd);
        acc_q  <= '0;
      end else begin
        acc_q <= acc_upd;
      end
    end
  end

endmodule
